// File: rtl/ccu_pkg.sv
// ccu_pkg -- definitions shared by the CCU packet-handling blocks.
//   * Packet type codes carried in the unpacker header.
//   * DAC write-engine state encoding.
//   * Beat limit, counter widths and the AXI OKAY response code.
//   * len_is_burst(): decides whether a DAC packet length becomes an AXI burst.
package ccu_pkg;

  localparam int MAX_BEATS = 256;  // largest AXI4 INCR burst
  localparam int CNT_W     = 9;    // holds 0..256 without wrapping
  localparam int LEN_W     = 13;   // width of pack_length

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam logic [2:0] PACKAGE_TYPE_CTRL = 3'd0;
  localparam logic [2:0] PACKAGE_TYPE_DAC  = 3'd1;
  localparam logic [2:0] PACKAGE_TYPE_ADC  = 3'd2;
  localparam logic [2:0] PACKAGE_TYPE_STAT = 3'd3;

  typedef enum logic [2:0] {
    DAC_IDLE = 3'd0,
    DAC_AW   = 3'd1,
    DAC_DATA = 3'd2,
    DAC_RESP = 3'd3,
    DAC_DROP = 3'd4
  } dac_state_e;

  // A packet is burst-able when it carries 1..max_beats data bytes after
  // the address byte, i.e. 2 <= len <= max_beats + 1.
  function automatic logic len_is_burst(input logic [LEN_W-1:0] len,
                                        input int max_beats);
    int l;
    l = int'(len);
    return (l >= 2) && (l <= max_beats + 1);
  endfunction

endpackage

// File: rtl/ccu_byte_fifo.sv
// ccu_byte_fifo -- synchronous byte FIFO buffering W-channel data.
//   clk, rst   : clock, asynchronous active-high reset (empties the FIFO)
//   push, din  : write a byte (ignored when full)
//   pop        : drop the head byte (ignored when empty)
//   dout       : head byte, valid whenever !empty
//   full/empty : occupancy flags
//   count      : current occupancy, 0..DEPTH
module ccu_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: the storage array has no reset; the pointers alone decide which
  // entries are valid, so clearing them is enough to empty the FIFO.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign count = wr_ptr - rd_ptr;
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/ccu_dac_fsm.sv
// ccu_dac_fsm -- turns DAC-type payloads from the unpacker into AXI4 writes.
// The first payload byte is the write address; the remaining bytes become
// one INCR burst of 8-bit beats. Out-of-range lengths are drained and
// flagged instead of being written.
//   axi_aclk, axi_areset : clock, asynchronous active-high reset
//   dac_fsm_dv/busy      : byte strobe in / backpressure out
//   pack_data/length     : payload byte and packet length (incl. address)
//   dac_axi_aw*          : AXI4 write-address channel (master)
//   dac_axi_w*           : AXI4 write-data channel (master)
//   dac_axi_b*           : AXI4 write-response channel (master)
//   dac_done             : one-cycle completion pulse
//   dac_err              : sticky error (bad response or dropped packet)
module ccu_dac_fsm #(
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_BEATS  = ccu_pkg::MAX_BEATS
) (
  input  logic        axi_aclk,
  input  logic        axi_areset,
  input  logic        dac_fsm_dv,
  output logic        dac_fsm_busy,
  input  logic [7:0]  pack_data,
  input  logic [12:0] pack_length,
  output logic [15:0] dac_axi_awaddr,
  output logic        dac_axi_awvalid,
  input  logic        dac_axi_awready,
  output logic [7:0]  dac_axi_wdata,
  output logic        dac_axi_wvalid,
  input  logic        dac_axi_wready,
  output logic        dac_axi_wlast,
  input  logic [1:0]  dac_axi_bresp,
  input  logic        dac_axi_bvalid,
  output logic        dac_axi_bready,
  output logic        dac_done,
  output logic        dac_err
);

  import ccu_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  dac_state_e       state_q, state_d;
  logic [15:0]      awaddr_q;
  logic [CNT_W-1:0] n_beats_q;   // data bytes in the current burst
  logic [CNT_W-1:0] rcv_cnt_q;   // data bytes taken from the unpacker
  logic [CNT_W-1:0] beat_cnt_q;  // W beats already handshaken
  logic [LEN_W-1:0] drop_cnt_q;  // bytes still to discard in DROP
  logic             done_q;
  logic             err_q;

  logic [LEN_W-1:0] len_m1;
  logic             len_ok;
  logic             len_short;
  logic             all_rcvd;
  logic             is_last;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic [7:0]       fifo_head;

  assign len_m1    = pack_length - 13'd1;
  assign len_ok    = len_is_burst(pack_length, MAX_BEATS);
  assign len_short = (pack_length <= 13'd1);  // nothing follows the first byte
  assign all_rcvd  = (rcv_cnt_q == n_beats_q);
  assign is_last   = (beat_cnt_q == CNT_W'(n_beats_q - 9'd1));

  ccu_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (axi_aclk),
    .rst   (axi_areset),
    .push  (push),
    .pop   (pop),
    .din   (pack_data),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) state_q <= DAC_IDLE;
    else            state_q <= state_d;
  end

  // NOTE: every combinational output gets a default before the case so no
  // path through the block leaves a value held, which would infer a latch.
  always_comb begin
    state_d         = state_q;
    dac_fsm_busy    = 1'b0;
    dac_axi_awvalid = 1'b0;
    dac_axi_wvalid  = 1'b0;
    dac_axi_wlast   = 1'b0;
    dac_axi_bready  = 1'b0;
    push            = 1'b0;
    pop             = 1'b0;

    case (state_q)
      DAC_IDLE: begin
        if (dac_fsm_dv) begin
          if (len_ok)          state_d = DAC_AW;
          else if (!len_short) state_d = DAC_DROP;
        end
      end
      DAC_AW: begin
        // Data bytes may already stream into the FIFO while AW waits.
        dac_fsm_busy    = fifo_full || all_rcvd;
        push            = dac_fsm_dv && !dac_fsm_busy;
        dac_axi_awvalid = 1'b1;
        if (dac_axi_awready) state_d = DAC_DATA;
      end
      DAC_DATA: begin
        dac_fsm_busy   = fifo_full || all_rcvd;
        push           = dac_fsm_dv && !dac_fsm_busy;
        dac_axi_wvalid = !fifo_empty;
        dac_axi_wlast  = dac_axi_wvalid && is_last;
        pop            = dac_axi_wvalid && dac_axi_wready;
        if (pop && is_last) state_d = DAC_RESP;
      end
      DAC_RESP: begin
        dac_fsm_busy   = 1'b1;
        dac_axi_bready = 1'b1;
        if (dac_axi_bvalid) state_d = DAC_IDLE;
      end
      DAC_DROP: begin
        if (dac_fsm_dv && (drop_cnt_q == 13'd1)) state_d = DAC_IDLE;
      end
      default: state_d = DAC_IDLE;
    endcase

    // Head is masked so wdata reads zero whenever no beat is offered.
    dac_axi_wdata = dac_axi_wvalid ? fifo_head : 8'h00;
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      awaddr_q   <= '0;
      n_beats_q  <= '0;
      rcv_cnt_q  <= '0;
      beat_cnt_q <= '0;
      drop_cnt_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        DAC_IDLE: begin
          if (dac_fsm_dv) begin
            rcv_cnt_q  <= '0;
            beat_cnt_q <= '0;
            if (len_ok) begin
              awaddr_q  <= {8'h00, pack_data};
              n_beats_q <= len_m1[CNT_W-1:0];
            end else if (len_short) begin
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else begin
              drop_cnt_q <= len_m1;
            end
          end
        end
        DAC_AW, DAC_DATA: begin
          if (push) rcv_cnt_q  <= rcv_cnt_q + 1'b1;
          if (pop)  beat_cnt_q <= beat_cnt_q + 1'b1;
        end
        DAC_RESP: begin
          if (dac_axi_bvalid) begin
            done_q <= 1'b1;
            if (dac_axi_bresp != RESP_OKAY) err_q <= 1'b1;
          end
        end
        DAC_DROP: begin
          if (dac_fsm_dv) begin
            drop_cnt_q <= drop_cnt_q - 1'b1;
            if (drop_cnt_q == 13'd1) begin
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign dac_axi_awaddr = awaddr_q;
  assign dac_done       = done_q;
  assign dac_err        = err_q;

  // busy keeps pushes away from a full FIFO, so occupancy stays in range.
  a_fifo_bound: assert property (@(posedge axi_aclk) disable iff (axi_areset)
                                 (fifo_count <= CW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_ccu_dac_fsm.sv
// tb_ccu_dac_fsm -- directed, table-driven bench for ccu_dac_fsm
// (FIFO_DEPTH = 4) with hand-written reset and back-to-back sequences.
module tb_ccu_dac_fsm;

  logic        clk;
  logic        rst;
  logic        dv;
  logic        busy;
  logic [7:0]  pack_data;
  logic [12:0] pack_length;
  logic [15:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [7:0]  wdata;
  logic        wvalid;
  logic        wready;
  logic        wlast;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic        done;
  logic        err;

  logic        awready_en;
  logic        wready_en;
  logic [1:0]  bresp_v;

  assign awready = awready_en;
  assign wready  = wready_en;
  assign bresp   = bresp_v;

  ccu_dac_fsm #(
    .FIFO_DEPTH (4),
    .MAX_BEATS  (256)
  ) dut (
    .axi_aclk        (clk),
    .axi_areset      (rst),
    .dac_fsm_dv      (dv),
    .dac_fsm_busy    (busy),
    .pack_data       (pack_data),
    .pack_length     (pack_length),
    .dac_axi_awaddr  (awaddr),
    .dac_axi_awvalid (awvalid),
    .dac_axi_awready (awready),
    .dac_axi_wdata   (wdata),
    .dac_axi_wvalid  (wvalid),
    .dac_axi_wready  (wready),
    .dac_axi_wlast   (wlast),
    .dac_axi_bresp   (bresp),
    .dac_axi_bvalid  (bvalid),
    .dac_axi_bready  (bready),
    .dac_done        (done),
    .dac_err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- bus monitor / AXI slave -----------------------------
  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } beat_t;

  logic [15:0] aw_q[$];
  beat_t       w_q[$];
  int          done_cnt = 0;
  int          viol     = 0;
  logic        p_awv, p_awr, p_wv, p_wr, p_wl;
  logic [7:0]  p_wd;

  initial bvalid = 1'b0;

  // Runs 2 time units after each falling edge: inputs are settled and the
  // values seen are those the next rising edge will act on.
  always @(negedge clk) begin
    #2;
    if (rst) begin
      p_awv = 1'b0; p_awr = 1'b0; p_wv = 1'b0; p_wr = 1'b0; p_wl = 1'b0; p_wd = 8'h00;
    end else begin
      if (awvalid && awready) aw_q.push_back(awaddr);
      if (wvalid && wready)   w_q.push_back({wlast, wdata});
      if (done)               done_cnt++;
      if (p_awv && !p_awr && !awvalid) viol++;
      if (p_wv && !p_wr && (!wvalid || wdata !== p_wd || wlast !== p_wl)) viol++;
      p_awv = awvalid; p_awr = awready; p_wv = wvalid; p_wr = wready;
      p_wl = wlast; p_wd = wdata;
    end
    bvalid = bready;
  end

  // ---------------- stimulus helpers ------------------------------------
  function automatic logic [7:0] data_byte(input int k);
    return 8'(k * 17);  // byte k of the payload (k >= 1): 0x11, 0x22, ...
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_pkt(input int len, input logic [7:0] addr,
                          output bit busy_seen, output bit aw_first);
    int  nbytes;
    int  guard;
    bit  pend;
    nbytes    = (len < 1) ? 1 : len;
    busy_seen = 1'b0;
    aw_first  = 1'b0;
    pend      = 1'b0;
    @(negedge clk);
    pack_length = 13'(len);
    for (int i = 0; i < nbytes; i++) begin
      dv        = 1'b1;
      pack_data = (i == 0) ? addr : data_byte(i);
      #1;
      if (pend) begin aw_first = awvalid; pend = 1'b0; end
      guard = 0;
      while (busy && guard < 2000) begin
        busy_seen = 1'b1;
        @(negedge clk);
        #1;
        guard++;
      end
      if (guard >= 2000) begin
        check("busy_timeout", 32'd1, 32'd0);
        break;
      end
      @(negedge clk);
      if (i == 0) pend = 1'b1;
    end
    dv = 1'b0;
    #1;
    if (pend) aw_first = awvalid;
  endtask

  task automatic run_pkt(input int len, input logic [7:0] addr, input int stall,
                         input logic [1:0] resp, output bit busy_seen, output bit aw_first);
    aw_q.delete();
    w_q.delete();
    done_cnt   = 0;
    viol       = 0;
    bresp_v    = resp;
    awready_en = 1'b1;
    wready_en  = (stall == 0);
    fork
      send_pkt(len, addr, busy_seen, aw_first);
      begin
        repeat (stall) @(negedge clk);
        wready_en = 1'b1;
      end
    join
    for (int c = 0; c < 3000 && done_cnt == 0; c++) @(negedge clk);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_pkt(input string tag, input logic [7:0] addr, input bit exp_aw,
                           input int exp_beats, input bit exp_err, input bit exp_busy,
                           input bit busy_seen, input bit aw_first);
    int derr;
    int lerr;
    derr = 0;
    lerr = 0;
    for (int k = 0; k < w_q.size(); k++) begin
      if (w_q[k].data !== data_byte(k + 1))          derr++;
      if (w_q[k].last !== (k == exp_beats - 1))      lerr++;
    end
    check({tag, "_aw_count"}, 32'(aw_q.size()), exp_aw ? 32'd1 : 32'd0);
    if (exp_aw && aw_q.size() > 0)
      check({tag, "_awaddr"}, 32'(aw_q[0]), {24'h0, addr});
    check({tag, "_aw_latency"}, 32'(aw_first), 32'(exp_aw));
    check({tag, "_beats"}, 32'(w_q.size()), 32'(exp_beats));
    check({tag, "_wdata_err"}, 32'(derr), 32'd0);
    check({tag, "_wlast_err"}, 32'(lerr), 32'd0);
    check({tag, "_done"}, 32'(done_cnt), 32'd1);
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    check({tag, "_busy_seen"}, 32'(busy_seen), 32'(exp_busy));
    check({tag, "_axi_hold"}, 32'(viol), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_awvalid"}, 32'(awvalid), 32'd0);
    check({tag, "_awaddr"},  32'(awaddr),  32'd0);
    check({tag, "_wvalid"},  32'(wvalid),  32'd0);
    check({tag, "_wdata"},   32'(wdata),   32'd0);
    check({tag, "_wlast"},   32'(wlast),   32'd0);
    check({tag, "_bready"},  32'(bready),  32'd0);
    check({tag, "_busy"},    32'(busy),    32'd0);
    check({tag, "_done"},    32'(done),    32'd0);
    check({tag, "_err"},     32'(err),     32'd0);
  endtask

  // ---------------- vector table ----------------------------------------
  typedef struct {
    int         len;
    logic [7:0] addr;
    int         stall;      // cycles wready is held low from packet start
    logic [1:0] resp;
    bit         exp_aw;
    int         exp_beats;
    bit         exp_err;
    bit         exp_busy;   // driver meets busy=1 while offering a byte
  } vec_t;

  vec_t vecs[10];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    bit busy_seen;
    bit aw_first;

    rst = 1'b1; dv = 1'b0; pack_data = 8'h00; pack_length = 13'd0;
    awready_en = 1'b1; wready_en = 1'b1; bresp_v = 2'b00;

    //          len  addr   stall resp   aw  beats err busy
    vecs[0] = '{  5, 8'h40,  0, 2'b00, 1'b1,   4, 1'b0, 1'b0};  // basic burst
    vecs[1] = '{  5, 8'h40, 20, 2'b00, 1'b1,   4, 1'b0, 1'b0};  // W stalled, all bytes buffered
    vecs[2] = '{  9, 8'hA5, 15, 2'b00, 1'b1,   8, 1'b0, 1'b1};  // W stalled, FIFO full -> busy
    vecs[3] = '{  2, 8'hFF,  0, 2'b00, 1'b1,   1, 1'b0, 1'b0};  // single beat
    vecs[4] = '{  1, 8'h00,  0, 2'b00, 1'b0,   0, 1'b1, 1'b0};  // address only
    vecs[5] = '{  0, 8'h00,  0, 2'b00, 1'b0,   0, 1'b1, 1'b0};  // zero length
    vecs[6] = '{300, 8'h00,  0, 2'b00, 1'b0,   0, 1'b1, 1'b0};  // oversize -> drop
    vecs[7] = '{257, 8'h12,  0, 2'b00, 1'b1, 256, 1'b0, 1'b0};  // maximum burst
    vecs[8] = '{258, 8'h12,  0, 2'b00, 1'b0,   0, 1'b1, 1'b0};  // one over maximum
    vecs[9] = '{  5, 8'h40,  0, 2'b10, 1'b1,   4, 1'b1, 1'b0};  // SLVERR response

    #1;
    check_reset_outputs("reset_init");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      do_reset();
      run_pkt(vecs[i].len, vecs[i].addr, vecs[i].stall, vecs[i].resp, busy_seen, aw_first);
      check_pkt($sformatf("v%0d", i), vecs[i].addr, vecs[i].exp_aw, vecs[i].exp_beats,
                vecs[i].exp_err, vecs[i].exp_busy, busy_seen, aw_first);
    end

    // After the SLVERR packet above (no reset): the next packet still runs
    // and the error flag stays set.
    run_pkt(3, 8'h20, 0, 2'b00, busy_seen, aw_first);
    check_pkt("after_slverr", 8'h20, 1'b1, 2, 1'b1, 1'b0, busy_seen, aw_first);

    // Reset in the middle of DATA after two of four beats.
    do_reset();
    aw_q.delete(); w_q.delete(); done_cnt = 0; viol = 0;
    bresp_v = 2'b00; awready_en = 1'b1; wready_en = 1'b1;
    fork
      send_pkt(5, 8'h40, busy_seen, aw_first);
      begin
        for (int c = 0; c < 200; c++) begin
          @(negedge clk);
          #1;
          if (w_q.size() >= 2) begin
            wready_en = 1'b0;
            break;
          end
        end
      end
    join
    repeat (2) @(negedge clk);
    check("mid_beats", 32'(w_q.size()), 32'd2);
    check("mid_wvalid", 32'(wvalid), 32'd1);
    check("mid_awaddr", 32'(awaddr), 32'h0040);
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    wready_en = 1'b1;
    run_pkt(3, 8'h80, 0, 2'b00, busy_seen, aw_first);
    check_pkt("post_reset", 8'h80, 1'b1, 2, 1'b0, 1'b0, busy_seen, aw_first);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ccu_dac_fsm.md
CCU_DAC_FSM -- requirements
Module: ccu_dac_fsm

Interface
REQ-001 Parameters: FIFO_DEPTH, default 16, W-channel byte buffer depth (power of two, >=4); MAX_BEATS, default 256, maximum data bytes per packet.
REQ-002 axi_aclk  in  1  sole clock; all logic rising-edge.
REQ-003 axi_areset  in  1  asynchronous, active-high reset.
REQ-004 dac_fsm_dv  in  1  payload byte strobe from unpacker for a DAC-type packet; a byte transfers on a cycle with dv=1 and busy=0.
REQ-005 dac_fsm_busy  out  1  backpressure to unpacker; unpacker holds pack_data while high.
REQ-006 pack_data  in  8  payload byte; first byte of a packet is the DAC write address.
REQ-007 pack_length  in  13  payload byte count including the address byte; valid and stable from the first dv of a packet until its last byte transfers.
REQ-008 dac_axi_awaddr/awvalid/awready  out/out/in  16/1/1  AXI4 write-address channel.
REQ-009 dac_axi_wdata/wvalid/wready/wlast  out/out/in/out  8/1/1/1  AXI4 write-data channel.
REQ-010 dac_axi_bresp/bvalid/bready  in/in/out  2/1/1  AXI4 write-response channel.
REQ-011 dac_done  out  1  one-cycle pulse when a packet completes (B handshake or drop finished).
REQ-012 dac_err  out  1  sticky error: set on bresp!=0 or dropped packet; cleared only by reset.

Function
REQ-013 States: IDLE, AW, DATA, RESP, DROP.
REQ-014 IDLE: busy=0; on first byte transfer, N = pack_length-1 is latched; if 1<=N<=MAX_BEATS, awaddr <= {8'h00, pack_data}, go AW; else go DROP with remaining count pack_length-1 (pack_length=0 or 1: no bytes remaining, dac_done and dac_err pulse/set next cycle, return IDLE).
REQ-015 AW: awvalid=1 with stable awaddr until awready sampled high, then DATA; data bytes accepted into FIFO during AW.
REQ-016 AW/DATA: busy = FIFO full OR all N data bytes already received; data bytes push into FIFO on transfer.
REQ-017 DATA: wvalid = FIFO non-empty; wdata = FIFO head; pop on wvalid&wready; wlast=1 exactly on beat N-1 (beats counted from 0).
REQ-018 DATA -> RESP on the handshake of the wlast beat; RESP: bready=1, busy=1.
REQ-019 RESP -> IDLE on bvalid; dac_done pulses the following cycle; if bresp!=2'b00, dac_err set.
REQ-020 DROP: busy=0; each transferred byte decrements remaining count and is discarded; at zero, dac_done pulses, dac_err set, return IDLE; no AXI activity.
REQ-021 Simultaneous FIFO push and pop in one cycle keeps occupancy unchanged; push when full never occurs (busy prevents it).
REQ-022 Beat counter and received-byte counter are 9 bits; no wrap permitted since N<=256.
REQ-023 awvalid and wvalid, once asserted, remain high until their handshake (AXI rule); wdata/wlast stable while wvalid&!wready.
REQ-024 Latency: address byte transfer to awvalid = 1 cycle; FIFO push to wvalid = 1 cycle.

Reset
REQ-025 On axi_areset assertion, mid-operation or otherwise: state IDLE, FIFO emptied, all counters 0, awvalid=wvalid=wlast=bready=0, awaddr=0, wdata=0, dac_fsm_busy=0, dac_done=0, dac_err=0; outstanding AXI transaction abandoned.
REQ-026 Deassertion takes effect on the next rising edge; no output glitches during reset.

Structure
REQ-027 Shared package ccu_pkg holds state enumeration encoding, PACKAGE_TYPE_* codes, MAX_BEATS and OKAY response constant.
REQ-028 FIFO is a separate sub-module ccu_byte_fifo (8-bit, FIFO_DEPTH, full/empty/count, same clock and reset).

Verification
REQ-029 pack_length=5, bytes 0x40,0x11,0x22,0x33,0x44, awready/wready always 1, bresp=0 -> awaddr=0x0040, 4 W beats 0x11..0x44, wlast on 0x44, one dac_done, dac_err=0.
REQ-030 Same packet, wready low for 20 cycles -> busy high after 4 data bytes buffered... FIFO_DEPTH=4: busy after FIFO full, no byte lost, wdata order preserved.
REQ-031 pack_length=1 -> no awvalid, dac_done pulse, dac_err=1; pack_length=300 -> 299 bytes consumed with busy=0, no AXI, dac_err=1.
REQ-032 pack_length=257 (256 beats) -> wlast only on beat 255, counters do not wrap.
REQ-033 bresp=2'b10 on a valid packet -> dac_done pulse, dac_err=1, next packet still processed.
REQ-034 axi_areset asserted in DATA after 2 of 4 beats -> all outputs at reset values same cycle; subsequent 3-byte packet completes normally.
